// File: rtl/im_fetch_sequencer.sv
// im_fetch_sequencer: serial program loader into IM followed by a stall/branch-aware fetch loop
module im_fetch_sequencer #(
  parameter int IM_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_inst,
  input  logic             i_inst_valid,
  output logic             im_we,
  output logic [IM_AW-1:0] im_waddr,
  output logic [15:0]      im_wdata,
  output logic             im_re,
  output logic [IM_AW-1:0] im_raddr,
  input  logic [15:0]      im_rdata,
  input  logic             i_stall,
  input  logic             i_br_valid,
  input  logic [IM_AW-1:0] i_br_target,
  output logic [15:0]      o_inst,
  output logic             o_inst_valid,
  output logic [IM_AW-1:0] o_pc,
  output logic             inCmd,
  output logic             o_is_done,
  output logic             o_load_err
);
  typedef enum logic [2:0] {LOAD_HI, LOAD_LO, SETTLE, RUN, DONE, ERR} state_t;
  state_t state, state_n;
  logic [7:0] hi;
  logic [IM_AW-1:0] wr_ptr, pc, pend_addr;
  logic pending, run, redirect, halt, lo_take;
  logic [15:0] word;
  // next state and the combinational fetch/decode-facing outputs
  always_comb begin
    word = {hi, i_inst};
    run = state == RUN;
    lo_take = state == LOAD_LO && i_inst_valid;
    redirect = run && !i_stall && i_br_valid;
    halt = run && pending && im_rdata == 16'hFFFF && !redirect;
    im_re = run && !i_stall && !i_br_valid;
    im_raddr = pc;
    o_inst = im_rdata;
    o_inst_valid = run && pending && im_rdata != 16'hFFFF;
    o_pc = pend_addr;
    inCmd = state == LOAD_HI || state == LOAD_LO;
    o_is_done = state == DONE;
    o_load_err = state == ERR;
    state_n = state;
    case (state)
      LOAD_HI: state_n = i_inst_valid ? LOAD_LO : LOAD_HI;
      LOAD_LO: state_n = !i_inst_valid ? LOAD_LO : word == 16'hFFFF ? SETTLE : &wr_ptr ? ERR : LOAD_HI;
      SETTLE:  state_n = RUN;
      RUN:     state_n = halt ? DONE : RUN;
      default: state_n = state;
    endcase
  end
  // state, load datapath with registered IM write, and fetch pointer tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_HI;
      hi <= '0;
      wr_ptr <= '0;
      pc <= '0;
      pending <= 1'b0;
      pend_addr <= '0;
      im_we <= 1'b0;
      im_waddr <= '0;
      im_wdata <= '0;
    end else begin
      state <= state_n;
      im_we <= lo_take;
      if (state == LOAD_HI && i_inst_valid) hi <= i_inst;
      if (lo_take) begin
        im_waddr <= wr_ptr;
        im_wdata <= word;
        wr_ptr <= wr_ptr + IM_AW'(1);
      end
      if (run && !i_stall) begin
        pc <= i_br_valid ? i_br_target : pc + IM_AW'(1);
        pending <= !i_br_valid;
        pend_addr <= pc;
      end
    end
  end
endmodule

// File: tb/tb_im_fetch_sequencer.sv
// tb_im_fetch_sequencer: directed load/fetch/stall/branch/overflow/reset checks with an IM model
module tb_im_fetch_sequencer;
  logic clk = 0, rst = 1;
  logic [7:0] i_inst = 0;
  logic i_inst_valid = 0, i_stall = 0, i_br_valid = 0;
  logic [7:0] i_br_target = 0;
  logic im_we, im_re, o_inst_valid, inCmd, o_is_done, o_load_err;
  logic [7:0] im_waddr, im_raddr, o_pc;
  logic [15:0] im_wdata, o_inst;
  logic [15:0] im_rdata = 0;
  logic [15:0] mem [256];
  logic we2, re2, iv2, cmd2, done2, err2;
  logic [1:0] waddr2, raddr2, pc2;
  logic [1:0] br_target2 = 0;
  logic [15:0] wdata2, inst2;
  logic [15:0] rdata2 = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_we) mem[im_waddr] <= im_wdata;
    if (im_re) im_rdata <= mem[im_raddr];
  end

  im_fetch_sequencer #(.IM_AW(8)) dut (
    .clk(clk), .rst(rst), .i_inst(i_inst), .i_inst_valid(i_inst_valid),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .im_re(im_re), .im_raddr(im_raddr), .im_rdata(im_rdata),
    .i_stall(i_stall), .i_br_valid(i_br_valid), .i_br_target(i_br_target),
    .o_inst(o_inst), .o_inst_valid(o_inst_valid), .o_pc(o_pc),
    .inCmd(inCmd), .o_is_done(o_is_done), .o_load_err(o_load_err));

  im_fetch_sequencer #(.IM_AW(2)) dut2 (
    .clk(clk), .rst(rst), .i_inst(i_inst), .i_inst_valid(i_inst_valid),
    .im_we(we2), .im_waddr(waddr2), .im_wdata(wdata2),
    .im_re(re2), .im_raddr(raddr2), .im_rdata(rdata2),
    .i_stall(i_stall), .i_br_valid(i_br_valid), .i_br_target(br_target2),
    .o_inst(inst2), .o_inst_valid(iv2), .o_pc(pc2),
    .inCmd(cmd2), .o_is_done(done2), .o_load_err(err2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_inst = b;
    i_inst_valid = 1;
    step();
    i_inst_valid = 0;
  endtask

  task automatic load_word(input logic [15:0] w);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic do_reset();
    i_stall = 0;
    i_br_valid = 0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, im_we, 0);
    chk({tag, "_waddr"}, im_waddr, 0);
    chk({tag, "_wdata"}, im_wdata, 0);
    chk({tag, "_re"}, im_re, 0);
    chk({tag, "_raddr"}, im_raddr, 0);
    chk({tag, "_ivalid"}, o_inst_valid, 0);
    chk({tag, "_pc"}, o_pc, 0);
    chk({tag, "_done"}, o_is_done, 0);
    chk({tag, "_err"}, o_load_err, 0);
    chk({tag, "_incmd"}, inCmd, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 0;
    step();
    step();
    chk_reset_vals("rst");
    rst = 0;
    send(8'h00);
    send(8'h12);
    chk("w0_we", im_we, 1);
    chk("w0_addr", im_waddr, 0);
    chk("w0_data", im_wdata, 16'h0012);
    send(8'h34);
    send(8'h56);
    send(8'hFF);
    chk("pre_term_incmd", inCmd, 1);
    send(8'hFF);
    chk("settle_incmd", inCmd, 0);
    chk("term_we", im_we, 1);
    chk("term_addr", im_waddr, 2);
    chk("term_data", im_wdata, 16'hFFFF);
    chk("settle_re", im_re, 0);
    step();
    chk("first_re", im_re, 1);
    chk("first_raddr", im_raddr, 0);
    chk("first_ivalid0", o_inst_valid, 0);
    step();
    chk("i0_valid", o_inst_valid, 1);
    chk("i0_inst", o_inst, 16'h0012);
    chk("i0_pc", o_pc, 0);
    step();
    chk("i1_valid", o_inst_valid, 1);
    chk("i1_inst", o_inst, 16'h3456);
    chk("i1_pc", o_pc, 1);
    step();
    chk("halt_valid", o_inst_valid, 0);
    chk("halt_done0", o_is_done, 0);
    step();
    chk("done", o_is_done, 1);
    chk("done_re", im_re, 0);
    chk("done_ivalid", o_inst_valid, 0);
    chk("mem0", mem[0], 16'h0012);
    chk("mem1", mem[1], 16'h3456);
    chk("mem2", mem[2], 16'hFFFF);

    do_reset();
    send(8'h12);
    send(8'hFF);
    send(8'hFF);
    send(8'h34);
    chk("mis_incmd", inCmd, 1);
    chk("mis_w1", im_wdata, 16'hFF34);
    chk("mis_a1", im_waddr, 1);
    send(8'hFF);
    send(8'hFF);
    chk("mis_end", inCmd, 0);
    step();
    chk("mis_mem0", mem[0], 16'h12FF);
    chk("mis_mem1", mem[1], 16'hFF34);
    chk("mis_mem2", mem[2], 16'hFFFF);

    do_reset();
    for (int i = 0; i < 7; i++) load_word(16'h1000 + 16'(i));
    load_word(16'hFFFF);
    step();
    step();
    chk("sb_pc0", o_pc, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      i_stall = 1;
      i_br_valid = (k == 0);
      i_br_target = 8'd6;
      #1;
      chk("stall_re", im_re, 0);
      chk("stall_valid", o_inst_valid, 1);
      chk("stall_inst", o_inst, 16'h1001);
      chk("stall_pc", o_pc, 1);
      step();
    end
    i_stall = 0;
    i_br_valid = 0;
    #1;
    chk("rel_valid", o_inst_valid, 1);
    chk("rel_pc", o_pc, 1);
    chk("rel_re", im_re, 1);
    chk("rel_raddr", im_raddr, 2);
    step();
    chk("res_inst", o_inst, 16'h1002);
    chk("res_pc", o_pc, 2);
    i_br_valid = 1;
    i_br_target = 8'd5;
    #1;
    chk("br_re", im_re, 0);
    step();
    i_br_valid = 0;
    #1;
    chk("bubble_valid", o_inst_valid, 0);
    chk("tgt_raddr", im_raddr, 5);
    step();
    chk("tgt_valid", o_inst_valid, 1);
    chk("tgt_pc", o_pc, 5);
    chk("tgt_inst", o_inst, 16'h1005);
    step();
    chk("tgt1_inst", o_inst, 16'h1006);
    step();
    chk("br_halt_valid", o_inst_valid, 0);
    step();
    chk("br_done", o_is_done, 1);

    do_reset();
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    rst = 1;
    step();
    chk_reset_vals("midrst");
    rst = 0;
    send(8'h01);
    send(8'h02);
    chk("midrst_we", im_we, 1);
    chk("midrst_addr", im_waddr, 0);
    chk("midrst_data", im_wdata, 16'h0102);

    do_reset();
    load_word(16'h0101);
    load_word(16'h0202);
    load_word(16'h0303);
    chk("ovf_err0", err2, 0);
    chk("ovf_cmd0", cmd2, 1);
    load_word(16'h0404);
    chk("ovf_err", err2, 1);
    chk("ovf_cmd", cmd2, 0);
    chk("ovf_re", re2, 0);
    step();
    chk("ovf_re2", re2, 0);
    chk("ovf_err_sticky", err2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
